// File: rtl/mte_arbiter_if.sv
// Requester-side port of the MTE arbiter: request with operands in, handshake and result out.
// The master modport is the host; the slave modport is the arbiter.
interface mte_arbiter_if #(
    parameter int N = 8
);
    logic         req;
    logic         sel;
    logic [N-1:0] key;
    logic [N-1:0] data;
    logic         ack;
    logic         done;
    logic [N-1:0] result;
    logic         valid;

    modport master (
        output req, sel, key, data,
        input  ack, done, result, valid
    );

    modport slave (
        input  req, sel, key, data,
        output ack, done, result, valid
    );
endinterface

// File: rtl/mte_arbiter.sv
// Round-robin arbiter that time-shares one MAC-then-encrypt engine between two hosts,
// holding engine inputs for LATENCY cycles and returning the result with a done pulse.
module mte_arbiter #(
    parameter int N       = 8,
    parameter int LATENCY = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    mte_arbiter_if.slave host0,
    mte_arbiter_if.slave host1,
    output logic [N-1:0] eng_key,
    output logic [N-1:0] eng_in,
    output logic         eng_sel,
    input  logic [N-1:0] eng_out,
    input  logic         eng_valid_key,
    output logic         busy
);
    localparam int CW = $clog2(LATENCY + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("mte_arbiter: LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          last_gnt;
    logic          gnt;
    logic          gnt_id;
    logic          capture;
    logic          sample;
    logic [N:0]    formed;

    // Decrypt results are only released when the MAC check passed; otherwise zeroed.
    function automatic logic [N:0] form_result(input logic sel, input logic [N-1:0] res,
                                               input logic mac_ok);
        if (sel)
            return {1'b1, res};
        else if (mac_ok)
            return {1'b1, res};
        else
            return {1'b0, {N{1'b0}}};
    endfunction

    assign formed = form_result(eng_sel, eng_out, eng_valid_key);
    assign busy   = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        sample    = 1'b0;
        // Port 0 wins unless port 1 also requests and port 0 was served last.
        gnt_id    = (host0.req && (!host1.req || last_gnt)) ? 1'b0 : 1'b1;
        case (state)
            IDLE: begin
                if (host0.req || host1.req) begin
                    capture   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    sample    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            eng_key  <= '0;
            eng_in   <= '0;
            eng_sel  <= 1'b0;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            cnt      <= '0;
        end else if (capture) begin
            eng_key  <= gnt_id ? host1.key  : host0.key;
            eng_in   <= gnt_id ? host1.data : host0.data;
            eng_sel  <= gnt_id ? host1.sel  : host0.sel;
            gnt      <= gnt_id;
            last_gnt <= gnt_id;
            cnt      <= CW'(LATENCY);
        end else if (state == BUSY) begin
            cnt      <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            host0.ack    <= 1'b0;
            host0.done   <= 1'b0;
            host0.result <= '0;
            host0.valid  <= 1'b0;
        end else begin
            host0.ack  <= capture && !gnt_id;
            host0.done <= sample && !gnt;
            if (sample && !gnt) begin
                host0.result <= formed[N-1:0];
                host0.valid  <= formed[N];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            host1.ack    <= 1'b0;
            host1.done   <= 1'b0;
            host1.result <= '0;
            host1.valid  <= 1'b0;
        end else begin
            host1.ack  <= capture && gnt_id;
            host1.done <= sample && gnt;
            if (sample && gnt) begin
                host1.result <= formed[N-1:0];
                host1.valid  <= formed[N];
            end
        end
    end
endmodule

// File: tb/tb_mte_arbiter.sv
// Directed bench for mte_arbiter: XOR engine stub, LATENCY=2 main instance and a LATENCY=5 instance.
module tb_mte_arbiter;
    localparam int N = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic ev = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    mte_arbiter_if #(.N(N)) h0 ();
    mte_arbiter_if #(.N(N)) h1 ();
    logic [N-1:0] e_key, e_in, e_out;
    logic         e_sel, busy;
    assign e_out = e_in ^ e_key;

    mte_arbiter #(.N(N), .LATENCY(2)) u_dut (
        .clock(clock), .reset_n(reset_n), .host0(h0), .host1(h1),
        .eng_key(e_key), .eng_in(e_in), .eng_sel(e_sel),
        .eng_out(e_out), .eng_valid_key(ev), .busy(busy)
    );

    mte_arbiter_if #(.N(N)) g0 ();
    mte_arbiter_if #(.N(N)) g1 ();
    logic [N-1:0] f_key, f_in, f_out;
    logic         f_sel, busy5;
    assign f_out = f_in ^ f_key;

    mte_arbiter #(.N(N), .LATENCY(5)) u_dut5 (
        .clock(clock), .reset_n(reset_n), .host0(g0), .host1(g1),
        .eng_key(f_key), .eng_in(f_in), .eng_sel(f_sel),
        .eng_out(f_out), .eng_valid_key(1'b1), .busy(busy5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        h0.req = 0; h0.sel = 0; h0.key = 0; h0.data = 0;
        h1.req = 0; h1.sel = 0; h1.key = 0; h1.data = 0;
        g0.req = 0; g0.sel = 0; g0.key = 0; g0.data = 0;
        g1.req = 0; g1.sel = 0; g1.key = 0; g1.data = 0;

        // Reset state
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_ack0", h0.ack, 0);
        check("rst_done0", h0.done, 0);
        check("rst_res0", h0.result, 0);
        check("rst_engkey", e_key, 0);
        check("rst_engsel", e_sel, 0);

        // Single encrypt on port 0
        reset_n = 1;
        h0.req = 1; h0.sel = 1; h0.key = 8'hA5; h0.data = 8'h3C;
        tick();
        check("enc_ack0", h0.ack, 1);
        check("enc_busy", busy, 1);
        check("enc_engkey", e_key, 8'hA5);
        check("enc_engin", e_in, 8'h3C);
        check("enc_engsel", e_sel, 1);
        h0.req = 0;
        tick();
        check("enc_ack0_off", h0.ack, 0);
        check("enc_done0_early", h0.done, 0);
        tick();
        check("enc_done0", h0.done, 1);
        check("enc_res0", h0.result, 8'h99);
        check("enc_val0", h0.valid, 1);
        check("enc_done1", h1.done, 0);
        check("enc_res1", h1.result, 0);
        check("enc_val1", h1.valid, 0);
        tick();
        check("enc_done0_off", h0.done, 0);
        check("enc_idle", busy, 0);
        check("enc_res0_hold", h0.result, 8'h99);

        // Decrypt on port 1, MAC fail then MAC pass
        for (int pass = 0; pass < 2; pass++) begin
            ev = pass[0];
            h1.req = 1; h1.sel = 0; h1.key = 8'h11; h1.data = 8'h22;
            tick();
            check("dec_ack1", h1.ack, 1);
            check("dec_ack0", h0.ack, 0);
            h1.req = 0;
            tick(); tick();
            check("dec_done1", h1.done, 1);
            check("dec_res1", h1.result, pass ? 8'h33 : 8'h00);
            check("dec_val1", h1.valid, pass ? 1 : 0);
            check("dec_res0_hold", h0.result, 8'h99);
            check("dec_done0", h0.done, 0);
            tick();
            check("dec_idle", busy, 0);
        end
        ev = 1;

        // Continuous tie from reset: 0,1,0,1 every 4 cycles
        reset_n = 0;
        tick();
        check("tie_rst_res1", h1.result, 0);
        reset_n = 1;
        h0.req = 1; h0.sel = 1; h0.key = 8'h01; h0.data = 8'h02;
        h1.req = 1; h1.sel = 1; h1.key = 8'h10; h1.data = 8'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tie_ack0", h0.ack, (i % 2 == 0) ? 1 : 0);
            check("tie_ack1", h1.ack, (i % 2 == 1) ? 1 : 0);
            tick(); tick();
            check("tie_done0", h0.done, (i % 2 == 0) ? 1 : 0);
            check("tie_done1", h1.done, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) check("tie_res0", h0.result, 8'h03);
            else            check("tie_res1", h1.result, 8'h30);
            tick();
            check("tie_idle", busy, 0);
        end
        h0.req = 0; h1.req = 0;

        // Reset asserted mid-transaction
        h1.req = 1; h1.sel = 1; h1.key = 8'h0F; h1.data = 8'h0F;
        tick();
        check("mid_ack1", h1.ack, 1);
        tick();
        reset_n = 0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_res1", h1.result, 0);
        check("mid_engkey", e_key, 0);
        h1.req = 0;
        tick();
        check("mid_done1", h1.done, 0);
        reset_n = 1;
        h0.req = 1; h0.sel = 1; h0.key = 8'hF0; h0.data = 8'h0F;
        h1.req = 1; h1.sel = 1; h1.key = 8'h00; h1.data = 8'h00;
        tick();
        check("mid_tie_ack0", h0.ack, 1);
        check("mid_tie_ack1", h1.ack, 0);
        h0.req = 0; h1.req = 0;
        tick(); tick();
        check("mid_done0", h0.done, 1);
        check("mid_res0", h0.result, 8'hFF);
        check("mid_done1_none", h1.done, 0);
        tick();

        // Short req0 pulse while port 1 is served
        h1.req = 1; h1.sel = 1; h1.key = 8'h55; h1.data = 8'hAA;
        tick();
        check("drop_ack1", h1.ack, 1);
        h1.req = 0; h0.req = 1;
        tick();
        check("drop_ack0_a", h0.ack, 0);
        h0.req = 0;
        tick();
        check("drop_done1", h1.done, 1);
        check("drop_done0", h0.done, 0);
        tick();
        check("drop_busy", busy, 0);
        tick();
        check("drop_ack0_b", h0.ack, 0);
        check("drop_busy_b", busy, 0);
        check("drop_done0_b", h0.done, 0);

        // LATENCY=5 instance
        g0.req = 1; g0.sel = 1; g0.key = 8'h0F; g0.data = 8'hF0;
        tick();
        check("l5_ack0", g0.ack, 1);
        g0.req = 0;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("l5_done_early", g0.done, 0);
            check("l5_busy", busy5, 1);
            check("l5_engkey", f_key, 8'h0F);
            check("l5_engin", f_in, 8'hF0);
        end
        tick();
        check("l5_done0", g0.done, 1);
        check("l5_res0", g0.result, 8'hFF);
        check("l5_val0", g0.valid, 1);
        check("l5_done1", g1.done, 0);
        tick();
        check("l5_idle", busy5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
